// File: rtl/axis_snooper_if.sv
// AXI-Stream observation bundle. The master side drives the bus; the snooper
// only listens on the slave side, including TREADY.
interface axis_snooper_if #(
  parameter int unsigned DATA_WIDTH = 64
) ();
  logic [DATA_WIDTH-1:0]   TDATA;
  logic [DATA_WIDTH/8-1:0] TKEEP;
  logic                    TVALID;
  logic                    TREADY;
  logic                    TLAST;

  modport master (output TDATA, TKEEP, TVALID, TREADY, TLAST);
  modport slave  (input  TDATA, TKEEP, TVALID, TREADY, TLAST);
endinterface

// File: rtl/axis_snooper.sv
// Passive AXI-Stream tap: claims a packet buffer, copies one whole packet into
// it word by word, then releases it. Packets starting with no buffer held are counted.
module axis_snooper #(
  parameter int unsigned SN_FWD_DATA_WIDTH = 64,
  parameter int unsigned SN_FWD_ADDR_WIDTH = 8,
  parameter int unsigned INC_WIDTH         = 4,
  parameter int unsigned DROP_CNT_WIDTH    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  axis_snooper_if.slave                snoop,
  output logic [SN_FWD_ADDR_WIDTH-1:0] sn_addr,
  output logic [SN_FWD_DATA_WIDTH-1:0] sn_wr_data,
  output logic                         sn_wr_en,
  output logic [INC_WIDTH-1:0]         sn_byte_inc,
  output logic                         sn_done,
  input  logic                         rdy_for_sn,
  output logic                         rdy_for_sn_ack,
  output logic [DROP_CNT_WIDTH-1:0]    drop_cnt
);

  localparam int unsigned KeepWidth = SN_FWD_DATA_WIDTH / 8;

  typedef enum logic [1:0] {StNobuf, StReady, StCapture, StTrunc} state_e;

  state_e                       state_q;
  logic                         sop_q;
  logic                         beat;
  logic [INC_WIDTH-1:0]         keep_cnt;
  logic [SN_FWD_ADDR_WIDTH-1:0] addr_inc;

  assign beat     = snoop.TVALID & snoop.TREADY;
  assign addr_inc = sn_addr + SN_FWD_ADDR_WIDTH'(1);

  // TKEEP is contiguous from bit 0, but a popcount is robust to any pattern.
  always_comb begin
    keep_cnt = '0;
    for (int i = 0; i < int'(KeepWidth); i++) begin
      keep_cnt = keep_cnt + INC_WIDTH'(snoop.TKEEP[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StNobuf;
      sop_q          <= 1'b1;
      sn_addr        <= '0;
      sn_wr_data     <= '0;
      sn_wr_en       <= 1'b0;
      sn_byte_inc    <= '0;
      sn_done        <= 1'b0;
      rdy_for_sn_ack <= 1'b0;
      drop_cnt       <= '0;
    end else begin
      sn_wr_en       <= 1'b0;
      sn_done        <= 1'b0;
      rdy_for_sn_ack <= 1'b0;

      // Packet boundaries are tracked regardless of buffer ownership.
      if (beat) begin
        sop_q <= snoop.TLAST;
      end

      unique case (state_q)
        StNobuf: begin
          if (beat && sop_q && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_CNT_WIDTH'(1);
          end
          if (rdy_for_sn) begin
            rdy_for_sn_ack <= 1'b1;
            state_q        <= StReady;
          end
        end

        // Only a packet's first beat may open a capture; a tail is ignored.
        StReady: begin
          if (beat && sop_q) begin
            sn_wr_en    <= 1'b1;
            sn_addr     <= '0;
            sn_wr_data  <= snoop.TDATA;
            sn_byte_inc <= keep_cnt;
            if (snoop.TLAST) begin
              sn_done <= 1'b1;
              state_q <= StNobuf;
            end else begin
              state_q <= StCapture;
            end
          end
        end

        StCapture: begin
          if (beat) begin
            sn_wr_en    <= 1'b1;
            sn_addr     <= addr_inc;
            sn_wr_data  <= snoop.TDATA;
            sn_byte_inc <= keep_cnt;
            if (snoop.TLAST) begin
              sn_done <= 1'b1;
              state_q <= StNobuf;
            end else if (addr_inc == '1) begin
              state_q <= StTrunc;
            end
          end
        end

        // Buffer full: swallow the rest, release on TLAST without writing.
        StTrunc: begin
          if (beat && snoop.TLAST) begin
            sn_done <= 1'b1;
            state_q <= StNobuf;
          end
        end

        default: state_q <= StNobuf;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_snooper.sv
// Bench for axis_snooper: a packet-level reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_axis_snooper;

  localparam int unsigned DW    = 64;
  localparam int unsigned AW    = 2;
  localparam int unsigned IW    = 4;
  localparam int unsigned CW    = 2;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk;
  logic          rst;
  logic          rdy_for_sn;
  logic [AW-1:0] sn_addr;
  logic [DW-1:0] sn_wr_data;
  logic          sn_wr_en;
  logic [IW-1:0] sn_byte_inc;
  logic          sn_done;
  logic          rdy_for_sn_ack;
  logic [CW-1:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  axis_snooper_if #(.DATA_WIDTH(DW)) snoop_bus ();

  axis_snooper #(
    .SN_FWD_DATA_WIDTH(DW),
    .SN_FWD_ADDR_WIDTH(AW),
    .INC_WIDTH        (IW),
    .DROP_CNT_WIDTH   (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .snoop         (snoop_bus.slave),
    .sn_addr       (sn_addr),
    .sn_wr_data    (sn_wr_data),
    .sn_wr_en      (sn_wr_en),
    .sn_byte_inc   (sn_byte_inc),
    .sn_done       (sn_done),
    .rdy_for_sn    (rdy_for_sn),
    .rdy_for_sn_ack(rdy_for_sn_ack),
    .drop_cnt      (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a packet is captured iff a buffer is held and idle when
  // its first beat arrives; beat k of it lands at address k while k < DEPTH.
  logic          m_claimed, m_in_pkt, m_capturing;
  int            m_idx;
  logic          exp_wr_en, exp_done, exp_ack;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic [IW-1:0] exp_inc;
  logic [CW-1:0] exp_drop;

  always @(posedge clk or negedge rst) begin
    logic was_claimed;
    logic beat_now;
    if (!rst) begin
      m_claimed = 0; m_in_pkt = 0; m_capturing = 0; m_idx = 0;
      exp_wr_en = 0; exp_done = 0; exp_ack = 0;
      exp_addr = '0; exp_data = '0; exp_inc = '0; exp_drop = '0;
    end else begin
      was_claimed = m_claimed;
      beat_now    = snoop_bus.TVALID && snoop_bus.TREADY;
      exp_wr_en = 0; exp_done = 0; exp_ack = 0;
      if (beat_now) begin
        if (!m_in_pkt) begin
          if (!was_claimed) begin
            if (exp_drop != {CW{1'b1}}) exp_drop = exp_drop + 1'b1;
          end else if (!m_capturing) begin
            m_capturing = 1;
            m_idx       = 0;
          end
        end
        if (m_capturing) begin
          if (m_idx < int'(DEPTH)) begin
            exp_wr_en = 1;
            exp_addr  = AW'(m_idx);
            exp_data  = snoop_bus.TDATA;
            exp_inc   = IW'($countones(snoop_bus.TKEEP));
          end
          m_idx++;
          if (snoop_bus.TLAST) begin
            exp_done    = 1;
            m_capturing = 0;
            m_claimed   = 0;
          end
        end
        m_in_pkt = !snoop_bus.TLAST;
      end
      if (!was_claimed && rdy_for_sn) begin
        exp_ack   = 1;
        m_claimed = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("wr_en", 64'(sn_wr_en), 64'(exp_wr_en));
    chk("done", 64'(sn_done), 64'(exp_done));
    chk("ack", 64'(rdy_for_sn_ack), 64'(exp_ack));
    chk("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    if (exp_wr_en) begin
      chk("addr", 64'(sn_addr), 64'(exp_addr));
      chk("wr_data", sn_wr_data, exp_data);
      chk("byte_inc", 64'(sn_byte_inc), 64'(exp_inc));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [DW-1:0] data, input logic [7:0] keep, input logic last);
    snoop_bus.TDATA  = data;
    snoop_bus.TKEEP  = keep;
    snoop_bus.TLAST  = last;
    snoop_bus.TVALID = 1'b1;
    snoop_bus.TREADY = 1'b1;
    @(posedge clk);
    #1;
    snoop_bus.TVALID = 1'b0;
    snoop_bus.TLAST  = 1'b0;
  endtask

  task automatic claim(input string name);
    rdy_for_sn = 1'b1;
    @(posedge clk);
    #1;
    rdy_for_sn = 1'b0;
    chk(name, 64'(rdy_for_sn_ack), 64'd1);
  endtask

  task automatic lit_write(input string name, input logic [AW-1:0] addr,
                           input logic [IW-1:0] inc, input logic done);
    chk({name, ".wr_en"}, 64'(sn_wr_en), 64'd1);
    chk({name, ".addr"}, 64'(sn_addr), 64'(addr));
    chk({name, ".inc"}, 64'(sn_byte_inc), 64'(inc));
    chk({name, ".done"}, 64'(sn_done), 64'(done));
  endtask

  task automatic lit_all_zero(input string name);
    chk({name, ".wr_en"}, 64'(sn_wr_en), 64'd0);
    chk({name, ".addr"}, 64'(sn_addr), 64'd0);
    chk({name, ".data"}, sn_wr_data, 64'd0);
    chk({name, ".inc"}, 64'(sn_byte_inc), 64'd0);
    chk({name, ".done"}, 64'(sn_done), 64'd0);
    chk({name, ".ack"}, 64'(rdy_for_sn_ack), 64'd0);
    chk({name, ".drop"}, 64'(drop_cnt), 64'd0);
  endtask

  initial begin
    rst = 1'b0;
    rdy_for_sn = 1'b0;
    snoop_bus.TDATA = '0; snoop_bus.TKEEP = '0;
    snoop_bus.TVALID = 1'b0; snoop_bus.TREADY = 1'b0; snoop_bus.TLAST = 1'b0;
    idle(3);
    lit_all_zero("reset");
    rst = 1'b1;
    idle(2);

    // Claim and short packet.
    claim("short.ack");
    idle(1);
    send(64'h0101_0101_0101_0101, 8'hFF, 1'b0);
    lit_write("short.b0", 2'd0, 4'd8, 1'b0);
    chk("short.b0.data", sn_wr_data, 64'h0101_0101_0101_0101);
    send(64'h0202_0202_0202_0202, 8'hFF, 1'b0);
    lit_write("short.b1", 2'd1, 4'd8, 1'b0);
    send(64'h0303_0303_0303_0303, 8'h0F, 1'b1);
    lit_write("short.b2", 2'd2, 4'd4, 1'b1);
    idle(1);
    chk("short.after.wr_en", 64'(sn_wr_en), 64'd0);

    // Single-beat packet.
    claim("single.ack");
    idle(1);
    send(64'hAAAA_0000_0000_BEEF, 8'h03, 1'b1);
    lit_write("single", 2'd0, 4'd2, 1'b1);
    chk("single.drop", 64'(drop_cnt), 64'd0);
    idle(2);

    // Misses while no buffer is held; counter saturates at all-ones (3).
    for (int p = 0; p < 3; p++) begin
      send(64'(p) + 64'h10, 8'hFF, 1'b0);
      send(64'(p) + 64'h20, 8'hFF, 1'b1);
      idle(1);
    end
    chk("miss.drop3", 64'(drop_cnt), 64'd3);
    send(64'h30, 8'hFF, 1'b1);
    idle(1);
    chk("miss.saturate", 64'(drop_cnt), 64'd3);

    // Claim lands on beat 2 of a 5-beat packet: the tail is not captured.
    send(64'h5001, 8'hFF, 1'b0);
    rdy_for_sn = 1'b1;
    send(64'h5002, 8'hFF, 1'b0);
    rdy_for_sn = 1'b0;
    chk("mid.ack", 64'(rdy_for_sn_ack), 64'd1);
    send(64'h5003, 8'hFF, 1'b0);
    chk("mid.b3.wr_en", 64'(sn_wr_en), 64'd0);
    send(64'h5004, 8'hFF, 1'b0);
    send(64'h5005, 8'hFF, 1'b1);
    chk("mid.b5.done", 64'(sn_done), 64'd0);
    idle(1);
    send(64'h6001, 8'h7F, 1'b0);
    lit_write("mid.next.b0", 2'd0, 4'd7, 1'b0);
    send(64'h6002, 8'h01, 1'b1);
    lit_write("mid.next.b1", 2'd1, 4'd1, 1'b1);
    idle(1);

    // TLAST exactly on the last address completes normally.
    claim("bound.ack");
    idle(1);
    for (int b = 0; b < 3; b++) send(64'h7000 + 64'(b), 8'hFF, 1'b0);
    send(64'h7003, 8'h3F, 1'b1);
    lit_write("bound.last", 2'd3, 4'd6, 1'b1);
    idle(1);

    // Overflow: 6 beats into a 4-word buffer; includes a zero-TKEEP beat.
    claim("ovf.ack");
    idle(1);
    send(64'h8000, 8'hFF, 1'b0);
    send(64'h8001, 8'h00, 1'b0);
    lit_write("ovf.b1", 2'd1, 4'd0, 1'b0);
    send(64'h8002, 8'hFF, 1'b0);
    send(64'h8003, 8'hFF, 1'b0);
    lit_write("ovf.b3", 2'd3, 4'd8, 1'b0);
    send(64'h8004, 8'hFF, 1'b0);
    chk("ovf.b4.wr_en", 64'(sn_wr_en), 64'd0);
    send(64'h8005, 8'hFF, 1'b1);
    chk("ovf.b5.wr_en", 64'(sn_wr_en), 64'd0);
    chk("ovf.b5.done", 64'(sn_done), 64'd1);
    idle(1);

    // Back-to-back: the packet right after TLAST is missed; claim on the same edge.
    claim("b2b.ack");
    idle(1);
    send(64'h9000, 8'hFF, 1'b1);
    chk("b2b.first.done", 64'(sn_done), 64'd1);
    rdy_for_sn = 1'b1;
    send(64'h9001, 8'hFF, 1'b1);
    rdy_for_sn = 1'b0;
    chk("b2b.missed.wr_en", 64'(sn_wr_en), 64'd0);
    chk("b2b.reclaim.ack", 64'(rdy_for_sn_ack), 64'd1);
    send(64'h9002, 8'h0F, 1'b1);
    lit_write("b2b.third", 2'd0, 4'd4, 1'b1);
    idle(1);

    // Asynchronous reset in the middle of a capture.
    claim("rst.ack");
    idle(1);
    send(64'hA000, 8'hFF, 1'b0);
    send(64'hA001, 8'hFF, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    lit_all_zero("rst.async");
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle(1);
    claim("rst.reclaim.ack");
    idle(1);
    send(64'hB000, 8'h1F, 1'b1);
    lit_write("rst.fresh", 2'd0, 4'd5, 1'b1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
